// File: rtl/sram_controller.sv
`default_nettype none
// sram_controller: turns each 32-bit MEM-stage load/store into two 16-bit accesses
// on an asynchronous 256K x 16 SRAM, holding ready low until the pair completes.
module sram_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeEn,
  input  logic        readEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        is_write;
  logic [16:0] word_addr;
  logic [15:0] wdata_hi;
  logic [15:0] rlow;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [31:0] offset;
  logic        req;

  // SRAM word index is the byte offset from BASE_ADDR with the byte lane bits dropped.
  assign offset = address - BASE_ADDR;
  assign req    = writeEn | readEn;
  assign ready  = (state == DONE) || ((state == IDLE) && !req);

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      is_write  <= 1'b0;
      word_addr <= 17'd0;
      wdata_hi  <= 16'd0;
      rlow      <= 16'd0;
      dq_out    <= 16'd0;
      dq_oe     <= 1'b0;
      readData  <= 32'd0;
      SRAM_ADDR <= 18'd0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_write  <= writeEn;
            word_addr <= offset[18:2];
            wdata_hi  <= writeData[31:16];
            cnt       <= 4'd0;
            state     <= LOW;
            SRAM_ADDR <= {offset[18:2], 1'b0};
            SRAM_WE_N <= ~writeEn;
            dq_oe     <= writeEn;
            dq_out    <= writeData[15:0];
          end
        end
        LOW: begin
          if (cnt == LAST_CNT) begin
            cnt       <= 4'd0;
            state     <= HIGH;
            SRAM_ADDR <= {word_addr, 1'b1};
            dq_out    <= wdata_hi;
            if (!is_write) rlow <= SRAM_DQ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == LAST_CNT) begin
            cnt       <= 4'd0;
            state     <= DONE;
            SRAM_ADDR <= 18'd0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!is_write) readData <= {SRAM_DQ, rlow};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// tb_sram_controller: randomized self-checking bench with an SRAM model and a
// transaction-level timeline/memory reference model.
module tb_sram_controller;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeEn, readEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

  int checks = 0;
  int errors = 0;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .writeEn(writeEn), .readEn(readEn),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus while not write-enabled, latches data while written.
  logic [15:0] sram [0:262143];
  assign sram_dq = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= sram_dq;

  // Reference model: 32-bit words keyed by SRAM word index, plus the last load result.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] written_q [$];
  logic [31:0] last_rd = 32'd0;

  function automatic logic [16:0] word_of(logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[18:2];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      writeEn = 1'b0; readEn = 1'b0; address = $urandom; writeData = $urandom;
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("idle_addr", {14'd0, SRAM_ADDR}, 32'd0);
      check("idle_rdata", readData, last_rd);
      @(posedge clk); #1;
    end
  endtask

  // One request: cycle 0 is the IDLE cycle presenting it, DONE is cycle 2W+1.
  task automatic run_access(bit wr, bit rd, logic [31:0] a, logic [31:0] d, int rst_at);
    logic [16:0] w;
    logic        in_low, in_high;
    logic [17:0] exp_addr;
    int          total;
    w     = word_of(a);
    total = 2 * W + 2;
    for (int k = 0; k < total; k++) begin
      if (k == 0) begin
        writeEn = wr; readEn = rd; address = a; writeData = d;
      end else begin
        writeEn = 1'($urandom); readEn = 1'($urandom); address = $urandom; writeData = $urandom;
      end
      if (k == rst_at) begin
        rst = 1'b1; writeEn = 1'b0; readEn = 1'b0;
      end
      @(negedge clk);
      if (k == rst_at) begin
        last_rd = 32'd0;
        if (wr && rst_at >= 2 && rst_at <= W + 1)
          ref_mem[32'(w)] = {ref_mem[32'(w)][31:16], d[15:0]};
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("rst_rdata", readData, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      in_low   = (k >= 1) && (k <= W);
      in_high  = (k > W) && (k <= 2 * W);
      exp_addr = in_low ? {w, 1'b0} : (in_high ? {w, 1'b1} : 18'd0);
      if (k == total - 1 && !wr) last_rd = ref_mem[32'(w)];
      check("ready", {31'd0, ready}, {31'd0, (k == total - 1)});
      check("we_n", {31'd0, SRAM_WE_N}, {31'd0, !(wr && (in_low || in_high))});
      check("sram_addr", {14'd0, SRAM_ADDR}, {14'd0, exp_addr});
      check("rdata", readData, last_rd);
      if (wr && in_low)  check("dq_low", {16'd0, sram_dq}, {16'd0, d[15:0]});
      if (wr && in_high) check("dq_high", {16'd0, sram_dq}, {16'd0, d[31:16]});
      @(posedge clk); #1;
    end
    if (wr) begin
      ref_mem[32'(w)] = d;
      written_q.push_back(a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; writeEn = 1'b0; readEn = 1'b0; address = '0; writeData = '0;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_rdata", readData, 32'd0);
    check("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("reset_addr", {14'd0, SRAM_ADDR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);

    run_access(1, 0, 32'd1024, 32'hDEADBEEF, -1);
    run_access(0, 1, 32'd1024, 32'h0, -1);
    check("load_1024", readData, 32'hDEADBEEF);
    run_access(1, 0, 32'd1028, 32'h12345678, -1);
    run_access(0, 1, 32'd1024, 32'h0, -1);
    run_access(0, 1, 32'd1028, 32'h0, -1);
    check("load_1028", readData, 32'h12345678);
    idle(1);
    run_access(1, 1, 32'd1032, 32'hA5A55A5A, -1);
    run_access(0, 1, 32'd1032, 32'h0, -1);
    check("load_1032", readData, 32'hA5A55A5A);
    run_access(1, 0, 32'd1036, 32'h0BADF00D, -1);
    run_access(1, 0, 32'd1036, 32'hCAFE1234, 3);
    run_access(0, 1, 32'd1036, 32'h0, -1);
    check("load_1036_partial", readData, 32'h0BAD1234);
    run_access(1, 0, 32'd1024 + 32'h0008_0000, 32'h11112222, -1);
    run_access(0, 1, 32'd1024, 32'h0, -1);
    run_access(1, 0, 32'd0, 32'h55AA00FF, -1);
    run_access(0, 1, 32'd0, 32'h0, -1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        run_access(0, 1, a, $urandom, -1);
      end else begin
        if ($urandom_range(0, 1) == 0) a = written_q[$urandom_range(0, written_q.size() - 1)];
        else a = {$urandom, 2'b00} >> 0;
        a[1:0] = 2'b00;
        run_access(1, (op == 2), a, $urandom, -1);
      end
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
